bus_arbitrator_multi: RTL and testbench

//  Parametrised N-master arbiter for the shared system bus; successor to the two-master CPU/DMA arbiter.

---
 rtl/bus_arbitrator_multi.sv | 166 ++++++++++++++++
 tb/tb_bus_arbitrator_multi.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbitrator_multi.sv
// ---------------------------------------------------------------------------
// bus_arbitrator_multi
//   N-master arbiter for the shared system bus. Grants one master at a time
//   using fixed-priority (MODE 0, lowest index wins) or round-robin (MODE 1)
//   selection, with an optional maximum tenure while others are waiting.
//   Every change of owner passes through a one-cycle turnaround (TURN) with
//   no grant; the shared bus lines are parked at 0 only while IDLE and are
//   left undriven (Z) otherwise so the owning master can drive them.
//
// Ports
//   clk            bus clock, rising edge
//   rst_n          asynchronous active-low reset
//   req            per-master request, held high for the whole tenure
//   grant          registered one-hot (or zero) grant
//   grant_idx      index of the current owner, 0 when nobody owns the bus
//   bus_busy       1 in GRANT and TURN
//   revoked        one-cycle pulse (during TURN) for an owner cut off by tenure
//   addr_bus, data_bus, wr_bus, rd_bus, data_mask_bus, fc_bus
//                  parked 0 in IDLE, Z otherwise
// ---------------------------------------------------------------------------
module bus_arbitrator_multi #(
    parameter int NUM_MASTERS = 4,
    parameter int MODE        = 0,
    parameter int MAX_TENURE  = 16,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   bus_busy,
    output logic [NUM_MASTERS-1:0] revoked,
    output logic [ADDR_W-1:0]      addr_bus,
    output logic [DATA_W-1:0]      data_bus,
    output logic                   wr_bus,
    output logic                   rd_bus,
    output logic [DATA_W/8-1:0]    data_mask_bus,
    output logic                   fc_bus
);

    localparam int TEN_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE + 1) : 1;
    localparam logic [TEN_W-1:0] TEN_MAX  = TEN_W'(MAX_TENURE);
    localparam logic [TEN_W-1:0] TEN_LAST = (MAX_TENURE > 0) ? TEN_W'(MAX_TENURE - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_grant_idx;
    logic                   r_busy;
    logic [NUM_MASTERS-1:0] r_revoked;
    logic [TEN_W-1:0]       r_tenure;
    logic [IDX_W-1:0]       r_rr_ptr;

    logic [NUM_MASTERS-1:0] w_cand;
    logic                   w_found;
    logic [IDX_W-1:0]       w_win;
    logic [IDX_W-1:0]       w_next_ptr;
    int unsigned            w_j;
    logic                   w_owner_req;
    logic                   w_others;
    logic                   w_park;

    // Winner search. r_revoked is only non-zero during TURN, so masking with
    // it excludes a just-revoked owner from exactly one arbitration.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_j     = 0;
        w_cand  = req & ~r_revoked;
        for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
            if (MODE == 1)
                w_j = (32'(r_rr_ptr) + off) % NUM_MASTERS;
            else
                w_j = off;
            if (!w_found && w_cand[w_j]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(w_j);
            end
        end
        w_next_ptr = IDX_W'((32'(w_win) + 1) % NUM_MASTERS);
    end

    assign w_owner_req = |(req & r_grant);
    assign w_others    = |(req & ~r_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_busy      <= 1'b0;
            r_revoked   <= '0;
            r_tenure    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_TURN: begin
                    r_revoked <= '0;
                    if (w_found) begin
                        r_state     <= S_GRANT;
                        r_grant     <= NUM_MASTERS'(1) << w_win;
                        r_grant_idx <= w_win;
                        r_busy      <= 1'b1;
                        r_tenure    <= '0;
                        if (MODE == 1)
                            r_rr_ptr <= w_next_ptr;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (MAX_TENURE != 0 && r_tenure != TEN_MAX)
                        r_tenure <= r_tenure + 1'b1;
                    if (!w_owner_req) begin
                        // Release: a new request in the same cycle still
                        // forces the turnaround rather than a trip via IDLE.
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                        if (w_others) begin
                            r_state <= S_TURN;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (MAX_TENURE != 0 && r_tenure == TEN_LAST && w_others) begin
                        r_state     <= S_TURN;
                        r_revoked   <= r_grant;
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_grant     <= '0;
                    r_grant_idx <= '0;
                    r_busy      <= 1'b0;
                    r_revoked   <= '0;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign grant_idx = r_grant_idx;
    assign bus_busy  = r_busy;
    assign revoked   = r_revoked;

    // Park the shared lines only while nobody can own the bus.
    assign w_park        = (r_state == S_IDLE);
    assign addr_bus      = w_park ? '0 : 'z;
    assign data_bus      = w_park ? '0 : 'z;
    assign wr_bus        = w_park ? 1'b0 : 1'bz;
    assign rd_bus        = w_park ? 1'b0 : 1'bz;
    assign data_mask_bus = w_park ? '0 : 'z;
    assign fc_bus        = w_park ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_bus_arbitrator_multi.sv
module tb_bus_arbitrator_multi;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // dut0: fixed priority, tenure 4.  dut1: round-robin, unlimited tenure.
    logic [3:0]  req0 = '0, req1 = '0;
    logic [3:0]  g0, g1, rv0, rv1;
    logic [1:0]  gi0, gi1;
    logic        bb0, bb1;
    logic [31:0] a0, a1, d0, d1;
    logic        wr0, wr1, rd0, rd1, fc0, fc1;
    logic [3:0]  m0b, m1b;

    bus_arbitrator_multi #(.NUM_MASTERS(4), .MODE(0), .MAX_TENURE(4), .ADDR_W(32), .DATA_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .grant(g0), .grant_idx(gi0), .bus_busy(bb0),
        .revoked(rv0), .addr_bus(a0), .data_bus(d0), .wr_bus(wr0), .rd_bus(rd0),
        .data_mask_bus(m0b), .fc_bus(fc0));

    bus_arbitrator_multi #(.NUM_MASTERS(4), .MODE(1), .MAX_TENURE(0), .ADDR_W(32), .DATA_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .grant(g1), .grant_idx(gi1), .bus_busy(bb1),
        .revoked(rv1), .addr_bus(a1), .data_bus(d1), .wr_bus(wr1), .rd_bus(rd1),
        .data_mask_bus(m1b), .fc_bus(fc1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Abstract model: who owns the bus, whether we are in the gap between
    // owners, how many cycles the owner has held, rr start point, and who
    // was just cut off.
    typedef struct {
        int owner;
        bit gap;
        int held;
        int ptr;
        int rev;
    } mdl_t;

    localparam mdl_t MRESET = '{owner: -1, gap: 1'b0, held: 0, ptr: 0, rev: -1};

    function automatic int pick(logic [3:0] r, int mode, int ptr, int excl);
        for (int off = 0; off < 4; off++) begin
            int j = (mode == 1) ? (ptr + off) % 4 : off;
            if (r[j] && j != excl) return j;
        end
        return -1;
    endfunction

    function automatic mdl_t mstep(mdl_t s, logic [3:0] r, int mode, int maxt);
        mdl_t n = s;
        int w;
        n.rev = -1;
        if (s.owner >= 0) begin
            if (!r[s.owner]) begin
                n.owner = -1;
                n.gap   = (r != 4'b0);
            end else if (maxt > 0 && s.held + 1 == maxt && (r & ~(4'b0001 << s.owner)) != 4'b0) begin
                n.owner = -1;
                n.gap   = 1'b1;
                n.rev   = s.owner;
            end else begin
                n.held = s.held + 1;
            end
        end else begin
            w = pick(r, mode, s.ptr, s.gap ? s.rev : -1);
            n.gap = 1'b0;
            if (w >= 0) begin
                n.owner = w;
                n.held  = 0;
                if (mode == 1) n.ptr = (w + 1) % 4;
            end
        end
        return n;
    endfunction

    mdl_t m0 = MRESET;
    mdl_t m1 = MRESET;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= MRESET;
            m1 <= MRESET;
        end else begin
            m0 <= mstep(m0, req0, 0, 4);
            m1 <= mstep(m1, req1, 1, 0);
        end
    end

    function automatic logic [3:0] onehot(int k);
        return (k >= 0) ? (4'b0001 << k) : 4'b0000;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m0.grant", 64'(g0), 64'(onehot(m0.owner)));
        chk("m0.grant_idx", 64'(gi0), 64'((m0.owner >= 0) ? m0.owner : 0));
        chk("m0.bus_busy", 64'(bb0), 64'((m0.owner >= 0) || m0.gap));
        chk("m0.revoked", 64'(rv0), 64'(onehot(m0.rev)));
        if (!((m0.owner >= 0) || m0.gap))
            chk("m0.park", 64'(|{a0, d0, wr0, rd0, m0b, fc0}), 64'(0));
        chk("m1.grant", 64'(g1), 64'(onehot(m1.owner)));
        chk("m1.grant_idx", 64'(gi1), 64'((m1.owner >= 0) ? m1.owner : 0));
        chk("m1.bus_busy", 64'(bb1), 64'((m1.owner >= 0) || m1.gap));
        chk("m1.revoked", 64'(rv1), 64'(onehot(m1.rev)));
        if (!((m1.owner >= 0) || m1.gap))
            chk("m1.park", 64'(|{a1, d1, wr1, rd1, m1b, fc1}), 64'(0));
    end

    // Advance n cycles; returns 1 time unit after a negedge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        chk("rst.grant", 64'(g0), 64'(0));
        chk("rst.idx", 64'(gi0), 64'(0));
        chk("rst.busy", 64'(bb0), 64'(0));
        chk("rst.addr", 64'(a0), 64'(0));
        rst_n = 1'b1;

        // 1: fixed priority picks the lowest index.
        req0 = 4'b0110;
        step(1);
        chk("t1.grant", 64'(g0), 64'(4'b0010));
        chk("t1.idx", 64'(gi0), 64'(1));
        chk("t1.busy", 64'(bb0), 64'(1));

        // 2: owner drops while 3 waits -> one turnaround cycle -> 3.
        req0 = 4'b1000;
        step(1);
        chk("t2.turn_grant", 64'(g0), 64'(0));
        chk("t2.turn_busy", 64'(bb0), 64'(1));
        step(1);
        chk("t2.grant", 64'(g0), 64'(4'b1000));
        chk("t2.idx", 64'(gi0), 64'(3));
        req0 = 4'b0000;
        step(1);
        chk("t2.idle_busy", 64'(bb0), 64'(0));
        chk("t2.idle_addr", 64'(a0), 64'(0));

        // 4: tenure expiry with 2 waiting.
        req0 = 4'b0101;
        step(1);
        chk("t4.grant_c1", 64'(g0), 64'(4'b0001));
        step(3);
        chk("t4.grant_c4", 64'(g0), 64'(4'b0001));
        chk("t4.rev_before", 64'(rv0), 64'(0));
        step(1);
        chk("t4.turn_grant", 64'(g0), 64'(0));
        chk("t4.revoked", 64'(rv0), 64'(4'b0001));
        step(1);
        chk("t4.grant2", 64'(g0), 64'(4'b0100));
        chk("t4.rev_clear", 64'(rv0), 64'(0));
        // 2 releases while 0 still waits: revoked master re-competes.
        req0 = 4'b0001;
        step(1);
        chk("t4.turn2", 64'(g0), 64'(0));
        step(1);
        chk("t4.regrant0", 64'(g0), 64'(4'b0001));

        // 5: lone owner never revoked.
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (i % 10 == 9) begin
                chk("t5.grant", 64'(g0), 64'(4'b0001));
                chk("t5.rev", 64'(rv0), 64'(0));
            end
        end

        // 6: asynchronous reset mid-grant, then re-grant after release.
        #2 rst_n = 1'b0;
        #1;
        chk("t6.grant_now", 64'(g0), 64'(0));
        chk("t6.addr_now", 64'(a0), 64'(0));
        chk("t6.busy_now", 64'(bb0), 64'(0));
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("t6.regrant", 64'(g0), 64'(4'b0001));
        req0 = 4'b0000;
        step(2);

        // 3: round-robin, each owner drops for one arbitration after 2 cycles.
        req1 = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("t3.grant", 64'(g1), 64'(4'b0001 << (k % 4)));
            chk("t3.idx", 64'(gi1), 64'(k % 4));
            step(1);
            req1 = 4'b1111 & ~(4'b0001 << (k % 4));
            step(1);
            chk("t3.turn", 64'(g1), 64'(0));
            chk("t3.turn_busy", 64'(bb1), 64'(1));
            req1 = 4'b1111;
        end
        req1 = 4'b0000;
        step(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
